// File: rtl/shift_seq_if.sv
// shift_seq_if: bundles the request, barrel-shifter and result signals of shift_seq.
//   in_valid/in_ready/in_data/in_amt : request handshake (shift in_data left by in_amt)
//   sh_a/sh_s/sh_y                   : operand, step amount and result of the external barrel
//   out_valid/out_ready/out_data/out_ovf : result handshake plus lost-bit flag
// slave  : seen from shift_seq
// master : seen from the surrounding environment (requester, barrel, consumer)
interface shift_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [WIDTH-1:0] sh_a;
  logic [1:0]       sh_s;
  logic [WIDTH-1:0] sh_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_amt, sh_y, out_ready,
    output in_ready, sh_a, sh_s, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_data, in_amt, sh_y, out_ready,
    input  in_ready, sh_a, sh_s, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/shift_seq.sv
// shift_seq: sequences a 0..7 position left shift through an external 2-bit-amount
// combinational barrel shifter, in greedy steps of at most STEP_MAX positions, feeding
// each barrel result back as the next operand.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : shift_seq_if.slave (request in, barrel operand/amount out, barrel result in,
//           result out with lost-bit flag)
module shift_seq #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AMT_W    = 3,
  parameter int unsigned STEP_MAX = 3
) (
  input logic         clk,
  input logic         rst_n,
  shift_seq_if.slave  bus
);

  localparam logic [AMT_W-1:0] StepMax = AMT_W'(STEP_MAX);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic [AMT_W-1:0] step;
  logic [WIDTH-1:0] lost_mask;

  always_comb begin
    step      = (rem_q < StepMax) ? rem_q : StepMax;
    // Top `step` bits of acc: the bits this barrel step pushes past the MSB.
    lost_mask = ~({WIDTH{1'b1}} >> step);

    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_data;
          rem_d   = bus.in_amt;
          ovf_d   = 1'b0;
          state_d = (bus.in_amt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        acc_d = bus.sh_y;
        rem_d = rem_q - step;  // step <= rem_q, never underflows
        ovf_d = ovf_q | (|(acc_q & lost_mask));
        if (rem_q == step) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outside SHIFT the barrel sees amount 0, so it simply passes acc through.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.sh_a      = acc_q;
  assign bus.sh_s      = (state_q == StShift) ? step[1:0] : 2'd0;
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = (state_q == StDone) ? acc_q : '0;
  assign bus.out_ovf   = (state_q == StDone) & ovf_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed and random requests for shift_seq; a behavioural barrel shifter
// closes the sh_a/sh_s -> sh_y loop, and expected results come from plain arithmetic.
module tb_shift_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  shift_seq_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_seq #(.WIDTH(8), .AMT_W(3), .STEP_MAX(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural barrel shifter.
  assign bus.sh_y = bus.sh_a << bus.sh_s;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_out_ovf"}, 32'(bus.out_ovf), 32'd0);
    chk({tag, "_sh_a"}, 32'(bus.sh_a), 32'd0);
    chk({tag, "_sh_s"}, 32'(bus.sh_s), 32'd0);
  endtask

  // Called at a negedge while idle; returns at the negedge just after the accepting edge.
  task automatic start(input logic [7:0] d, input logic [2:0] a);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_amt   = 3'($urandom);
  endtask

  // Follows one request from the negedge after acceptance until it is taken.
  task automatic finish(input logic [7:0] d, input logic [2:0] a, input int stall);
    logic [15:0] wide;
    logic [7:0]  part;
    int          exp_steps[$];
    int          rem;
    int          lat;
    int          got_lat;
    wide = {8'h00, d} << a;
    rem  = int'(a);
    while (rem > 0) begin
      exp_steps.push_back((rem > 3) ? 3 : rem);
      rem -= exp_steps[$];
    end
    lat     = 1 + (int'(a) + 2) / 3;
    got_lat = 0;
    part    = d;
    for (int k = 1; k <= 10; k++) begin
      if (bus.out_valid) begin
        got_lat = k;
        break;
      end
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      chk("sh_a", 32'(bus.sh_a), 32'(part));
      if (k - 1 < exp_steps.size()) begin
        chk("sh_s", 32'(bus.sh_s), 32'(exp_steps[k-1]));
        part = part << exp_steps[k-1];
      end else begin
        chk("sh_s_extra", 32'(bus.sh_s), 32'd0);
      end
      @(negedge clk);
    end
    chk("latency", 32'(got_lat), 32'(lat));
    chk("out_data", 32'(bus.out_data), 32'(wide[7:0]));
    chk("out_ovf", 32'(bus.out_ovf), 32'(|wide[15:8]));
    chk("sh_s_done", 32'(bus.sh_s), 32'd0);
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(wide[7:0]));
        chk("hold_ovf", 32'(bus.out_ovf), 32'(|wide[15:8]));
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] a;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_amt    = 3'd0;
    bus.out_ready = 1'b0;

    // Reset takes effect with no clock edge.
    #2;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-step, 3-step, zero-amount and stalled-output requests.
    start(8'hC7, 3'd3); finish(8'hC7, 3'd3, 0);
    start(8'h01, 3'd7); finish(8'h01, 3'd7, 0);
    start(8'hA5, 3'd0); finish(8'hA5, 3'd0, 0);
    start(8'h0F, 3'd5); finish(8'h0F, 3'd5, 5);

    // Reset during the second SHIFT cycle of an amt-6 request.
    start(8'h5A, 3'd6);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_valid_after_rst", 32'(bus.out_valid), 32'd0);
      chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
    end
    start(8'h01, 3'd1); finish(8'h01, 3'd1, 0);

    // Back-to-back: second request held on in_valid while busy, accepted on first IDLE cycle.
    bus.out_ready = 1'b1;
    start(8'h81, 3'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    bus.in_amt   = 3'd4;
    finish(8'h81, 3'd1, 0);
    start(8'h03, 3'd4); finish(8'h03, 3'd4, 0);

    // Random requests with random output stalls.
    repeat (24) begin
      d = 8'($urandom);
      a = 3'($urandom);
      start(d, a);
      finish(d, a, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
